// File: rtl/coord_entry_pkg.sv
// Shared constants, state encoding and BCD arithmetic for the coordinate entry front end.
package coord_entry_pkg;

    typedef enum logic [2:0] {
        ST_X_TENS = 3'd0,
        ST_X_ONES = 3'd1,
        ST_Y_TENS = 3'd2,
        ST_Y_ONES = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0]  DIGIT_MAX     = 4'd9;
    localparam int unsigned DEF_MAX_COORD = 31;
    localparam int unsigned DEF_COORD_W   = 5;

    // Two BCD digits to binary; 99 fits the 7-bit result.
    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/coord_entry_if.sv
// Valid/ready coordinate handoff from the entry front end to the position/attack logic.
interface coord_entry_if
    import coord_entry_pkg::*;
#(
    parameter int unsigned COORD_W = DEF_COORD_W
);
    logic               coord_valid;
    logic               coord_ready;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;

    modport master (output coord_valid, output x_out, output y_out, input coord_ready);
    modport slave  (input coord_valid, input x_out, input y_out, output coord_ready);
endinterface

// File: rtl/coord_entry_press_edge.sv
// Registered rising-edge detector for a push button, qualified by a global enable.
module coord_entry_press_edge (
    input  logic clk,
    input  logic en,
    input  logic lvl,
    output logic press
);
    logic lvl_q;

    // Level is tracked even while disabled so re-enabling never fakes an edge.
    always_ff @(posedge clk) begin
        lvl_q <= lvl;
    end

    assign press = en & lvl & ~lvl_q;
endmodule

// File: rtl/coord_entry.sv
// Four-digit BCD coordinate entry with range check and valid/ready handoff.
module coord_entry
    import coord_entry_pkg::*;
#(
    parameter int unsigned COORD_W   = DEF_COORD_W,
    parameter int unsigned MAX_COORD = DEF_MAX_COORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [3:0]          digit_in,
    input  logic                enter,
    input  logic                back,
    coord_entry_if.master       coord,
    output logic [2:0]          phase,
    output logic                err
);
    localparam logic [6:0] MAXV = 7'(MAX_COORD);

    state_t             state, state_n;
    logic [3:0]         xt, xt_n, yt, yt_n;
    logic [COORD_W-1:0] xo, xo_n, yo, yo_n;
    logic               valid, valid_n, err_n;
    logic [6:0]         x_val, y_val;
    logic               enter_p, back_p;

    coord_entry_press_edge u_enter (.clk(clk), .en(en), .lvl(enter), .press(enter_p));
    coord_entry_press_edge u_back  (.clk(clk), .en(en), .lvl(back),  .press(back_p));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_X_TENS;
            xt    <= '0;
            yt    <= '0;
            xo    <= '0;
            yo    <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            xt    <= xt_n;
            yt    <= yt_n;
            xo    <= xo_n;
            yo    <= yo_n;
            valid <= valid_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        xt_n    = xt;
        yt_n    = yt;
        xo_n    = xo;
        yo_n    = yo;
        valid_n = valid;
        err_n   = err;
        x_val   = bcd2bin(xt, digit_in);
        y_val   = bcd2bin(yt, digit_in);

        if (state == ST_HOLD) begin
            // Handshake completes regardless of en; buttons are ignored here.
            if (valid && coord.coord_ready) begin
                valid_n = 1'b0;
                state_n = ST_X_TENS;
                xt_n    = '0;
                yt_n    = '0;
            end
        end else if (back_p) begin
            state_n = ST_X_TENS;
            xt_n    = '0;
            yt_n    = '0;
        end else if (enter_p) begin
            if (digit_in > DIGIT_MAX) begin
                err_n = 1'b1;
            end else begin
                err_n = 1'b0;
                case (state)
                    ST_X_TENS: begin
                        xt_n    = digit_in;
                        state_n = ST_X_ONES;
                    end
                    ST_X_ONES: begin
                        if (x_val > MAXV) begin
                            err_n   = 1'b1;
                            xt_n    = '0;
                            state_n = ST_X_TENS;
                        end else begin
                            xo_n    = x_val[COORD_W-1:0];
                            state_n = ST_Y_TENS;
                        end
                    end
                    ST_Y_TENS: begin
                        yt_n    = digit_in;
                        state_n = ST_Y_ONES;
                    end
                    ST_Y_ONES: begin
                        if (y_val > MAXV) begin
                            err_n   = 1'b1;
                            yt_n    = '0;
                            state_n = ST_Y_TENS;
                        end else begin
                            yo_n    = y_val[COORD_W-1:0];
                            valid_n = 1'b1;
                            state_n = ST_HOLD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign coord.coord_valid = valid;
    assign coord.x_out       = xo;
    assign coord.y_out       = yo;
    assign phase             = 3'(state);
endmodule

// File: doc/coord_entry.md
Name: coord_entry

Overview:
Player-input front end for the battle board: the reverse of the coordinate-to-decimal-digit display path.
- Collects a target coordinate as four decimal digits (X tens, X ones, Y tens, Y ones), one digit per button press.
- Converts the digits to binary and range-checks each coordinate.
- Hands the (x, y) pair to the position/attack logic over a valid/ready handshake.

Parameters:
COORD_W, 5, width of each binary coordinate output
MAX_COORD, 31, largest legal coordinate value; must be ≤ 99 and ≤ 2^COORD_W−1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  global enable; when low, FSM and data registers hold
digit_in  input  4  BCD digit from switches; values 10–15 illegal
enter  input  1  level from push button; a rising edge commits digit_in
back  input  1  level from push button; a rising edge aborts entry
coord_ready  input  1  consumer accepts coordinate
coord_valid  output  1  x_out/y_out hold a complete, legal coordinate
x_out  output  COORD_W  binary X
y_out  output  COORD_W  binary Y
phase  output  3  current state encoding, for display/LEDs
err  output  1  sticky error flag

Behaviour:
- Edge detect:
  - enter_q and back_q register the previous levels every cycle, regardless of en. Releasing en therefore never produces a phantom edge.
  - A press is counted when the level is high at cycle N, was low at N−1, and en=1 at N.
  - A held button counts once.
- States and phase encoding: X_TENS=0, X_ONES=1, Y_TENS=2, Y_ONES=3, HOLD=4.
- Reset: state X_TENS; all digit registers 0; x_out=0, y_out=0, coord_valid=0, err=0.
  - Reset mid-entry or in HOLD discards everything.
  - coord_valid drops in the cycle after rst is sampled.
- Digit press in X_TENS/X_ONES/Y_TENS/Y_ONES:
  - digit_in > 9: the press is rejected, the state is unchanged and err is set.
  - digit_in ≤ 9: the digit is latched, the state advances at N+1 and err is cleared.
- Arithmetic: value = tens*10 + ones in a 7-bit intermediate, compared against MAX_COORD. Truncation to COORD_W happens only after the check passes.
- Leaving X_ONES with a legal digit:
  - If X > MAX_COORD: err=1, return to X_TENS and clear the X digits.
  - Otherwise latch x_out and go to Y_TENS.
- Leaving Y_ONES with a legal digit:
  - If Y > MAX_COORD: err=1, return to Y_TENS; X is retained.
  - Otherwise latch y_out, go to HOLD and assert coord_valid at N+1.
- HOLD:
  - coord_valid=1; x_out/y_out are stable.
  - enter and back are ignored.
  - When coord_valid & coord_ready are sampled high (en irrelevant; the handshake always completes), next cycle: coord_valid=0, state X_TENS, digit registers cleared.
  - x_out/y_out keep their last values until overwritten.
- Back press in any entry state: return to X_TENS and clear the digit registers; err is unchanged.
- Enter and back rising edges in the same cycle: back wins.
- en=0 in an entry state: no state or data change; coord_valid is unaffected.
- coord_ready in a non-HOLD state: ignored.

Decomposition:
- Shared package constants:
  - state encodings (ST_X_TENS…ST_HOLD)
  - DIGIT_MAX=9
  - default MAX_COORD=31
  - COORD_W=5
- One natural sub-module: press_edge (single-bit registered rising-edge detector with enable qualification), instantiated twice, for enter and back.
- The BCD-to-binary multiply-add with range check stays inline.

Test Plan:
- Legal entry and handshake: digits 1,2,0,7, each with one enter pulse, coord_ready=0 → phase 4, coord_valid=1, x_out=12, y_out=7.
  - Hold coord_ready=0 for 5 cycles → outputs stable.
  - Raise coord_ready for 1 cycle → coord_valid=0 and phase=0 next cycle.
- Out-of-range coordinates:
  - X entered as 3,5 → err=1, phase 0, coord_valid stays 0.
  - Then 3,1,4,0 → err=0, x_out=31; y 40 → err=1, phase 2, x_out still 31.
  - Then 0,9 → coord_valid=1, y_out=9.
- Illegal digit: digit_in=11 with enter → phase unchanged, err=1; next press with digit_in=4 advances phase and clears err.
- Held button and enable gating:
  - enter held high for 4 cycles → exactly one phase advance.
  - en=0 during a press, then en=1 while the button is still held → no advance.
- Back and enter together: after X=2,3, assert back and enter in the same cycle → phase 0, no digit committed; enter/back pressed in HOLD → no effect.
- Reset mid-operation: rst pulsed in Y_ONES, and separately in HOLD → next cycle phase 0, coord_valid=0, x_out=0, y_out=0, err=0.
